// File: rtl/exu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exu_pkg
// Description : Shared types and constants for the multiply/divide unit:
//               RV32M funct3 encodings, FSM state encoding, default width.
// Revision    : 1.0 - initial release
// ============================================================================
package exu_pkg;

    localparam int XLEN_DEFAULT = 32;

    // funct3 encodings of the RV32M operations
    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mdu_state_e;

endpackage
`default_nettype wire

// File: rtl/exu_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : exu_mdu_iter
// Description : Combinational single-step datapath shared by the iterative
//               operations: one restoring-divide step (MSB first) or one
//               shift-add multiply step (multiplier LSB first).
//               Divide : i_hi = partial remainder, i_lo = dividend/quotient.
//               Multiply: {i_hi, i_lo} = product accumulator, i_lo[0] is the
//               current multiplier bit, i_b = multiplicand.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_mdu_iter
    import exu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            i_is_div,
    input  logic [XLEN:0]   i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN:0]   o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;
    logic [XLEN:0] w_sum;

    // One divide or multiply step selected by the operation class.
    always_comb begin
        // Divide: bring the next dividend bit into the remainder, trial subtract.
        w_shift = {i_hi[XLEN-1:0], i_lo[XLEN-1]};
        w_diff  = w_shift - {1'b0, i_b};
        // Multiply: conditionally add the multiplicand to the upper half.
        // The upper half is always below 2^XLEN, so the carry lands in bit XLEN.
        w_sum   = i_hi + (i_lo[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
        if (i_is_div) begin
            // A borrow (negative difference) means the quotient bit is 0: restore.
            o_hi = w_diff[XLEN] ? w_shift : w_diff;
            o_lo = {i_lo[XLEN-2:0], ~w_diff[XLEN]};
        end else begin
            o_hi = {1'b0, w_sum[XLEN:1]};
            o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/exu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : exu_mdu
// Description : RV32M multiply/divide execution unit with valid/ready
//               handshakes. Operands are converted to magnitudes on accept,
//               the magnitude result is sign-corrected on entry to DONE.
//               Multiply is single-cycle (FAST_MUL=1) or iterative; divide is
//               always iterative, one quotient bit per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module exu_mdu
    import exu_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int FAST_MUL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_rd_wen,
    input  logic [4:0]      i_rd_addr,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_rd_wen,
    output logic [4:0]      o_rd_addr
);

    localparam int                 c_CNT_W     = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_LAST_STEP = c_CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]    c_INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          r_state;
    logic [2:0]          r_op;
    logic                r_neg;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [XLEN:0]       r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_b;
    logic [XLEN-1:0]     r_result;
    logic                r_rd_wen;
    logic [4:0]          r_rd_addr;

    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic                w_neg_flag;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic [XLEN-1:0]     w_special;
    logic [XLEN-1:0]     w_fast_res;
    logic [2*XLEN-1:0]   w_fast_prod;

    logic [XLEN:0]       w_next_hi;
    logic [XLEN-1:0]     w_next_lo;
    logic [2*XLEN-1:0]   w_prod;
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;
    logic [XLEN-1:0]     w_final;

    // Request decode: operand signedness, magnitudes, result sign, special cases.
    always_comb begin
        w_a_signed = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
        w_b_signed = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                     (i_op == OP_DIV) || (i_op == OP_REM);
        w_a_neg    = w_a_signed && i_rs1[XLEN-1];
        w_b_neg    = w_b_signed && i_rs2[XLEN-1];
        w_mag_a    = w_a_neg ? -i_rs1 : i_rs1;
        w_mag_b    = w_b_neg ? -i_rs2 : i_rs2;
        // Remainder follows the dividend; everything else follows signA ^ signB.
        w_neg_flag = (i_op == OP_REM) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div_zero = i_op[2] && (i_rs2 == '0);
        w_div_ovf  = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                     (i_rs1 == c_INT_MIN) && (i_rs2 == '1);
        // i_op[1] distinguishes REM/REMU from DIV/DIVU within the divide group.
        if (i_op[1]) begin
            w_special = w_div_zero ? i_rs1 : '0;
        end else begin
            w_special = w_div_zero ? '1 : i_rs1;
        end
        w_fast_res = (i_op == OP_MUL) ? w_fast_prod[XLEN-1:0] : w_fast_prod[2*XLEN-1:XLEN];
    end

    generate
        if (FAST_MUL != 0) begin : g_fast_mul
            logic [2*XLEN-1:0] w_prod_mag;
            assign w_prod_mag  = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
            assign w_fast_prod = w_neg_flag ? -w_prod_mag : w_prod_mag;
        end else begin : g_iter_mul
            assign w_fast_prod = '0;
        end
    endgenerate

    exu_mdu_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi     (w_next_hi),
        .o_lo     (w_next_lo)
    );

    // Sign fix-up and result selection applied to the final iterative step.
    always_comb begin
        w_prod     = {w_next_hi[XLEN-1:0], w_next_lo};
        w_prod_fix = r_neg ? -w_prod : w_prod;
        w_quo_fix  = r_neg ? -w_next_lo : w_next_lo;
        w_rem_fix  = r_neg ? -w_next_hi[XLEN-1:0] : w_next_hi[XLEN-1:0];
        case (r_op)
            OP_MUL:                       w_final = w_prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              w_final = w_quo_fix;
            default:                      w_final = w_rem_fix;
        endcase
    end

    // Control FSM together with operand, step-counter and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_rd_wen  <= 1'b0;
            r_rd_addr <= '0;
        end else if (i_flush) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_op      <= i_op;
                        r_neg     <= w_neg_flag;
                        r_rd_wen  <= i_rd_wen;
                        r_rd_addr <= i_rd_addr;
                        r_cnt     <= '0;
                        r_hi      <= '0;
                        // Divide shifts the dividend out of r_lo; multiply
                        // consumes the multiplier from r_lo.
                        if (i_op[2]) begin
                            r_lo <= w_mag_a;
                            r_b  <= w_mag_b;
                        end else begin
                            r_lo <= w_mag_b;
                            r_b  <= w_mag_a;
                        end
                        if (w_div_zero || w_div_ovf) begin
                            r_result <= w_special;
                            r_state  <= DONE;
                        end else if (!i_op[2] && (FAST_MUL != 0)) begin
                            r_result <= w_fast_res;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_hi  <= w_next_hi;
                    r_lo  <= w_next_lo;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    if (r_cnt == c_LAST_STEP) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready   = (r_state == IDLE);
    assign o_valid   = (r_state == DONE);
    assign o_result  = r_result;
    assign o_rd_wen  = r_rd_wen;
    assign o_rd_addr = r_rd_addr;

endmodule
`default_nettype wire

// File: tb/tb_exu_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_exu_mdu
// Description : Self-checking bench for exu_mdu. One instance with the
//               single-cycle multiplier, one with the iterative multiplier.
//               Expected results and latencies are queued on issue and
//               popped when the unit presents its result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exu_mdu;
    import exu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Single-cycle multiply instance
    logic        i_valid, i_rd_wen, i_flush, i_ready;
    logic [2:0]  i_op;
    logic [31:0] i_rs1, i_rs2;
    logic [4:0]  i_rd_addr;
    logic        o_ready, o_valid, o_rd_wen;
    logic [31:0] o_result;
    logic [4:0]  o_rd_addr;

    // Iterative multiply instance
    logic        s_i_valid, s_i_rd_wen, s_i_flush, s_i_ready;
    logic [2:0]  s_i_op;
    logic [31:0] s_i_rs1, s_i_rs2;
    logic [4:0]  s_i_rd_addr;
    logic        s_o_ready, s_o_valid, s_o_rd_wen;
    logic [31:0] s_o_result;
    logic [4:0]  s_o_rd_addr;

    exu_mdu #(.XLEN(32), .FAST_MUL(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd_wen(i_rd_wen), .i_rd_addr(i_rd_addr),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
        .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr)
    );

    exu_mdu #(.XLEN(32), .FAST_MUL(0)) dut_slow (
        .clk(clk), .rst_n(rst_n), .i_valid(s_i_valid), .o_ready(s_o_ready), .i_op(s_i_op),
        .i_rs1(s_i_rs1), .i_rs2(s_i_rs2), .i_rd_wen(s_i_rd_wen), .i_rd_addr(s_i_rd_addr),
        .i_flush(s_i_flush), .o_valid(s_o_valid), .i_ready(s_i_ready), .o_result(s_o_result),
        .o_rd_wen(s_o_rd_wen), .o_rd_addr(s_o_rd_addr)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        wen;
        logic [4:0]  rd;
        logic [7:0]  lat;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Reference RV32M behaviour built from native wide arithmetic.
    function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      ps;
        logic [63:0] pu;
        logic        ovf;
        sa  = a;
        sb  = b;
        pu  = {32'h0, a} * {32'h0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin ps = longint'(sa) * longint'(sb); return ps[31:0]; end
            3'd1: begin ps = longint'(sa) * longint'(sb); return ps[63:32]; end
            3'd2: begin ps = longint'(sa) * longint'({32'h0, b}); return ps[63:32]; end
            3'd3: return pu[63:32];
            3'd4: begin
                if (b == 32'h0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            3'd5: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'h0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: return (b == 32'h0) ? a : a % b;
        endcase
    endfunction

    // Expected accept-to-valid latency in cycles.
    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit fast);
        if (!op[2]) return fast ? 1 : 33;
        if (b == 32'h0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic wen, input logic [4:0] rd);
        @(negedge clk);
        i_valid = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b; i_rd_wen = wen; i_rd_addr = rd;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!o_valid && lat < 100);
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv, input logic wen, input logic [4:0] rd,
                          output exp_t want, output exp_t got);
        int lat;
        sbq.push_back('{res: expv, wen: wen, rd: rd, lat: 8'(ref_lat(op, a, b, 1'b1))});
        issue(op, a, b, wen, rd);
        wait_result(lat);
        got  = '{res: o_result, wen: o_rd_wen, rd: o_rd_addr, lat: (o_valid ? 8'(lat) : 8'hFF)};
        want = sbq.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_ready, o_valid, o_rd_wen, o_rd_addr, o_result} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_fast: got ready=%b valid=%b wen=%b rd=%0d res=%h, want ready=1 valid=0 wen=0 rd=0 res=0",
                     o_ready, o_valid, o_rd_wen, o_rd_addr, o_result);
        end
        checks++;
        if ({s_o_ready, s_o_valid, s_o_rd_wen, s_o_rd_addr, s_o_result} !== {1'b1, 1'b0, 1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_slow: got ready=%b valid=%b wen=%b rd=%0d res=%h, want ready=1 valid=0 wen=0 rd=0 res=0",
                     s_o_ready, s_o_valid, s_o_rd_wen, s_o_rd_addr, s_o_result);
        end
    endtask

    task automatic test_mul_fast();
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ev  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        exp_t want, got;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], ev[i], 1'(i), 5'(i + 3), want, got);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mul_fast[%0d]: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                         i, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
            end
        end
    endtask

    task automatic test_mul_iter();
        logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd3, 3'd2};
        logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
        logic [31:0] ev  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
        exp_t want, got;
        int   lat;
        for (int i = 0; i < 4; i++) begin
            sbq.push_back('{res: ev[i], wen: 1'b1, rd: 5'(20 + i), lat: 8'(ref_lat(ops[i], av[i], bv[i], 1'b0))});
            @(negedge clk);
            s_i_valid = 1'b1; s_i_op = ops[i]; s_i_rs1 = av[i]; s_i_rs2 = bv[i];
            s_i_rd_wen = 1'b1; s_i_rd_addr = 5'(20 + i);
            @(posedge clk);
            #1 s_i_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!s_o_valid && lat < 100);
            got  = '{res: s_o_result, wen: s_o_rd_wen, rd: s_o_rd_addr, lat: (s_o_valid ? 8'(lat) : 8'hFF)};
            want = sbq.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL mul_iter[%0d]: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                         i, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [4] = '{3'd4, 3'd6, 3'd5, 3'd7};
        logic [31:0] av  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
        logic [31:0] bv  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
        logic [31:0] ev  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
        exp_t want, got;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], av[i], bv[i], ev[i], 1'b1, 5'(10 + i), want, got);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL div[%0d]: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                         i, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
            end
        end
    endtask

    task automatic test_div_special();
        logic [2:0]  ops [6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd6, 3'd5};
        logic [31:0] av  [6] = '{32'd1234, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'h8000_0000};
        logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9, 32'd0};
        exp_t want, got;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], av[i], bv[i], ev[i], 1'(~i), 5'(25 + i), want, got);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL div_special[%0d]: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                         i, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t        want, got;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 16; i++) begin
            op = 3'(i % 8);
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            run_op(op, a, b, ref_mdu(op, a, b), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), want, got);
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL b2b[%0d] op=%0d a=%h b=%h: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                         i, op, a, b, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
            end
            @(negedge clk);
            checks++;
            if ({o_ready, o_valid} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_handoff[%0d]: got ready=%b valid=%b, want ready=1 valid=0", i, o_ready, o_valid);
            end
        end
    endtask

    task automatic test_hold();
        exp_t want, got;
        i_ready = 1'b0;
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 5'd17, want, got);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL hold_result: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                     got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({o_ready, o_valid, o_result, o_rd_wen, o_rd_addr} !== {1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 5'd17}) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got ready=%b valid=%b res=%h wen=%b rd=%0d, want ready=0 valid=1 res=fffffffe wen=1 rd=17",
                         k, o_ready, o_valid, o_result, o_rd_wen, o_rd_addr);
            end
        end
        i_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL hold_release: got ready=%b valid=%b, want ready=1 valid=0", o_ready, o_valid);
        end
    endtask

    // Abort a DIV at cycle 10 with either flush or reset, then run a MUL.
    task automatic test_abort(input bit use_reset);
        exp_t  want, got;
        bit    seen;
        string nm;
        nm   = use_reset ? "reset_mid" : "flush";
        seen = 1'b0;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 5'd9);
        for (int c = 1; c < 10; c++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        @(negedge clk);
        if (use_reset) rst_n = 1'b0; else i_flush = 1'b1;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if ({o_ready, o_valid} !== 2'b10) begin
            errors++;
            $display("FAIL %s_idle: got ready=%b valid=%b, want ready=1 valid=0", nm, o_ready, o_valid);
        end
        if (use_reset) begin
            checks++;
            if ({o_rd_wen, o_rd_addr, o_result, s_o_result} !== {1'b0, 5'd0, 32'd0, 32'd0}) begin
                errors++;
                $display("FAIL reset_mid_regs: got wen=%b rd=%0d res=%h slow_res=%h, want wen=0 rd=0 res=0 slow_res=0",
                         o_rd_wen, o_rd_addr, o_result, s_o_result);
            end
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s_no_result: got o_valid seen=1, want 0", nm);
        end
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, 5'd4, want, got);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s_followup: got res=%h wen=%b rd=%0d lat=%0d, want res=%h wen=%b rd=%0d lat=%0d",
                     nm, got.res, got.wen, got.rd, got.lat, want.res, want.wen, want.rd, want.lat);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_valid = 1'b0; i_op = '0; i_rs1 = '0; i_rs2 = '0; i_rd_wen = 1'b0; i_rd_addr = '0;
        i_flush = 1'b0; i_ready = 1'b1;
        s_i_valid = 1'b0; s_i_op = '0; s_i_rs1 = '0; s_i_rs2 = '0; s_i_rd_wen = 1'b0; s_i_rd_addr = '0;
        s_i_flush = 1'b0; s_i_ready = 1'b1;

        test_reset();
        test_mul_fast();
        test_mul_iter();
        test_div();
        test_div_special();
        test_back_to_back();
        test_hold();
        test_abort(1'b0);
        test_abort(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, want completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/exu_mdu.md
# exu_mdu

Parametrised multiply/divide execution unit implementing the RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) with a valid/ready handshake. It sits beside the single-cycle integer ALU in the execute stage. It takes decoded operands plus the destination register and returns a result with the rd write-back information passed through. Multiplication is either single-cycle or iterative, selected by parameter. Division is always iterative, one quotient bit per cycle.

## Interface
- XLEN, 32: operand/result width; must be ≥ 8 and a power of 2.
- FAST_MUL, 1: 1 = single-cycle multiply; 0 = iterative shift-add multiply, XLEN cycles.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- i_valid  in  1  request valid.
- o_ready  out  1  unit can accept; high only in IDLE.
- i_op  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rs1  in  XLEN  operand A; dividend for divide ops.
- i_rs2  in  XLEN  operand B; divisor for divide ops.
- i_rd_wen  in  1  write enable, captured on accept.
- i_rd_addr  in  5  destination register, captured on accept.
- i_flush  in  1  abort any in-flight operation.
- o_valid  out  1  result valid; high only in DONE.
- i_ready  in  1  consumer accepts result.
- o_result  out  XLEN  result.
- o_rd_wen  out  1  captured i_rd_wen.
- o_rd_addr  out  5  captured i_rd_addr.

## Operation
- States: IDLE, CALC, DONE. State is IDLE after reset.
- Accept: i_valid && o_ready && !i_flush. On accept, latch op, operands, rd_wen, rd_addr and the sign flags.
- Signed operands are converted to magnitudes on accept. The result is negated on entry to DONE when the sign flag is set:
  - MUL*: sign flag = signA ^ signB.
  - DIV: sign flag = signA ^ signB.
  - REM: sign flag = signA (sign of dividend).
- MULHSU treats rs1 as signed and rs2 as unsigned.
- MUL returns the low XLEN bits of the 2·XLEN product. MULH/MULHSU/MULHU return the high XLEN bits.
- Transitions from IDLE on accept:
  - Divide by zero → DONE directly. DIV/DIVU return all-ones; REM/REMU return rs1.
  - Signed overflow (DIV/REM with rs1 = 1<<(XLEN-1) and rs2 = all-ones) → DONE directly. DIV returns rs1; REM returns 0.
  - Multiply with FAST_MUL=1 → DONE directly.
  - All other cases → CALC, with the step counter loaded to 0.
- CALC, divide: restoring division, one quotient bit per cycle, MSB first. The remainder register is XLEN+1 bits.
- CALC, multiply with FAST_MUL=0: shift-add, one multiplier bit per cycle, into a 2·XLEN accumulator.
- CALC exit: after XLEN steps (counter = XLEN-1 on the last step) → DONE.
- DONE: o_result, o_rd_wen and o_rd_addr are held stable until i_ready. DONE && i_ready → IDLE.
- i_flush in any state → IDLE next cycle. Flush has priority over accept and over DONE handoff. A flushed result is never presented.
- A new request is not accepted in the same cycle a result is handed off; o_ready is low in DONE.

## Timing
- Reset (rst_n low at a clk edge) → IDLE. After reset: o_valid 0, o_result 0, o_rd_wen 0, o_rd_addr 0. o_ready reads 1 in the first cycle after deassertion.
- Reset mid-operation: aborts CALC/DONE with the same effect as reset.
- With accept at cycle T, o_valid rises at:
  - T+1 for special divide cases and FAST_MUL=1 multiply.
  - T+XLEN+1 for iterative divide and FAST_MUL=0 multiply.
- o_ready and o_valid are decoded directly from registered state; there are no combinational paths from i_valid/i_ready to them.
- Throughput: one op per (latency + 1) cycles when i_ready is held high.

## Structure
- Package exu_pkg holds:
  - mdu_op_e, the funct3 encodings above.
  - mdu_state_e: IDLE, CALC, DONE.
  - The XLEN default constant.
- Sub-module exu_mdu_iter: the per-cycle restoring-divide / shift-add step datapath. It is combinational, parameterised by XLEN, and instantiated once. The top-level holds the FSM, counter, registers and sign fix-up.

## Test plan
- MUL 7 × -3, FAST_MUL=1 → o_valid at T+1, result 0xFFFFFFEB. Same with FAST_MUL=0 → o_valid at T+33.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV -7 / 2 → -3 (0xFFFFFFFD). REM -7 / 2 → -1. DIVU 100 / 7 → 14. REMU → 2. o_valid at T+33.
- DIV x / 0 → 0xFFFFFFFF. REMU 5 / 0 → 5. DIV 0x80000000 / -1 → 0x80000000. REM of the same → 0. All at T+1.
- Hold i_ready low 5 cycles in DONE → result, rd_wen and rd_addr stable. Release → IDLE, o_ready high the next cycle.
- Assert i_flush at cycle 10 of a DIV → o_valid never rises, IDLE next cycle. A following MUL completes correctly. Repeat with rst_n low mid-CALC.
